// File: rtl/ram_op_sequencer.sv
// Command FIFO and handshake driver for ram_controller. Queued list ops are issued one at
// a time over the level-enable / finished_op handshake, guarded by a per-op watchdog.
module ram_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [9:0]  req_arg1,
    input  logic [9:0]  req_arg2,
    output logic        rsp_valid,
    output logic [1:0]  rsp_op,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        ctl_enable,
    output logic [1:0]  ctl_select_op,
    output logic [9:0]  ctl_arg1,
    output logic [9:0]  ctl_arg2,
    input  logic        ctl_finished_op,
    input  logic [31:0] ctl_out1
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ENT_W = 22;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WD_W-1:0]    wd_r;
    logic [WD_W-1:0]    wd_next_s;

    logic [ENT_W-1:0]   fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [ENT_W-1:0]   head_s;
    logic               push_s;
    logic               pop_s;

    logic               ctl_enable_r;
    logic               ctl_enable_next_s;
    logic [1:0]         ctl_select_op_r;
    logic [1:0]         ctl_select_op_next_s;
    logic [9:0]         ctl_arg1_r;
    logic [9:0]         ctl_arg1_next_s;
    logic [9:0]         ctl_arg2_r;
    logic [9:0]         ctl_arg2_next_s;

    logic               rsp_valid_r;
    logic               rsp_valid_next_s;
    logic [1:0]         rsp_op_r;
    logic [1:0]         rsp_op_next_s;
    logic [31:0]        rsp_data_r;
    logic [31:0]        rsp_data_next_s;
    logic               rsp_err_r;
    logic               rsp_err_next_s;

    logic               req_ready_r;
    logic               req_ready_next_s;
    logic               busy_r;
    logic               busy_next_s;

    assign push_s = req_valid && req_ready_r;
    assign head_s = fifo_mem_r[rd_ptr_r];

    // Next-state, watchdog and controller-side/response register values
    always_comb begin
        state_next_s         = state_r;
        wd_next_s            = wd_r;
        pop_s                = 1'b0;
        ctl_enable_next_s    = ctl_enable_r;
        ctl_select_op_next_s = ctl_select_op_r;
        ctl_arg1_next_s      = ctl_arg1_r;
        ctl_arg2_next_s      = ctl_arg2_r;
        rsp_valid_next_s     = 1'b0;
        rsp_op_next_s        = rsp_op_r;
        rsp_data_next_s      = rsp_data_r;
        rsp_err_next_s       = rsp_err_r;
        case (state_r)
            ST_HOLD: begin
                // The hold lets a controller op that was in flight at reset drain out.
                ctl_enable_next_s = 1'b0;
                if (wd_r == WD_LAST) begin
                    state_next_s = ST_RELEASE;
                    wd_next_s    = '0;
                end else begin
                    wd_next_s = wd_r + WD_ONE;
                end
            end
            ST_IDLE: begin
                if (count_r != '0) begin
                    pop_s                = 1'b1;
                    ctl_enable_next_s    = 1'b1;
                    ctl_select_op_next_s = head_s[21:20];
                    ctl_arg1_next_s      = head_s[19:10];
                    ctl_arg2_next_s      = head_s[9:0];
                    wd_next_s            = '0;
                    state_next_s         = ST_RUN;
                end else begin
                    ctl_enable_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (ctl_finished_op) begin
                    ctl_enable_next_s = 1'b0;
                    rsp_valid_next_s  = 1'b1;
                    rsp_op_next_s     = ctl_select_op_r;
                    rsp_data_next_s   = ctl_out1;
                    rsp_err_next_s    = 1'b0;
                    state_next_s      = ST_RELEASE;
                end else if (wd_r == WD_LAST) begin
                    ctl_enable_next_s = 1'b0;
                    rsp_valid_next_s  = 1'b1;
                    rsp_op_next_s     = ctl_select_op_r;
                    rsp_data_next_s   = 32'h0000_0000;
                    rsp_err_next_s    = 1'b1;
                    state_next_s      = ST_RELEASE;
                end else begin
                    wd_next_s = wd_r + WD_ONE;
                end
            end
            ST_RELEASE: begin
                // The controller only leaves its done state once it has seen enable low.
                ctl_enable_next_s = 1'b0;
                if (!ctl_finished_op) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            default: begin
                ctl_enable_next_s = 1'b0;
                wd_next_s         = '0;
                state_next_s      = ST_HOLD;
            end
        endcase
    end

    // FIFO occupancy and the status flags derived from next-cycle state
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
        req_ready_next_s = (count_next_s < CNT_FULL) && (state_next_s != ST_HOLD);
        busy_next_s      = (state_next_s == ST_RUN) || (state_next_s == ST_RELEASE) ||
                           (count_next_s != '0);
    end

    // FIFO storage; pointers are reset, so contents need no reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {req_op, req_arg1, req_arg2};
        end
    end

    // State, watchdog, pointers and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_HOLD;
            wd_r            <= '0;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            count_r         <= '0;
            ctl_enable_r    <= 1'b0;
            ctl_select_op_r <= 2'd0;
            ctl_arg1_r      <= 10'd0;
            ctl_arg2_r      <= 10'd0;
            rsp_valid_r     <= 1'b0;
            rsp_op_r        <= 2'd0;
            rsp_data_r      <= 32'h0000_0000;
            rsp_err_r       <= 1'b0;
            req_ready_r     <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            wd_r            <= wd_next_s;
            count_r         <= count_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            ctl_enable_r    <= ctl_enable_next_s;
            ctl_select_op_r <= ctl_select_op_next_s;
            ctl_arg1_r      <= ctl_arg1_next_s;
            ctl_arg2_r      <= ctl_arg2_next_s;
            rsp_valid_r     <= rsp_valid_next_s;
            rsp_op_r        <= rsp_op_next_s;
            rsp_data_r      <= rsp_data_next_s;
            rsp_err_r       <= rsp_err_next_s;
            req_ready_r     <= req_ready_next_s;
            busy_r          <= busy_next_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign busy          = busy_r;
    assign ctl_enable    = ctl_enable_r;
    assign ctl_select_op = ctl_select_op_r;
    assign ctl_arg1      = ctl_arg1_r;
    assign ctl_arg2      = ctl_arg2_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_op        = rsp_op_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;

endmodule
